// File: rtl/row_padding_if.sv
// Pixel stream bundle (data, sideband, routing tag, handshake, end of row) shared by
// the slave and master sides of the row padding stage.
interface row_padding_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 5,
    parameter int TDEST_WIDTH = 2
) ();
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (
        output tdata,
        output tuser,
        output tdest,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tdest,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/row_padding.sv
// Vertical border stage: replicates the first and last row of each frame twice more
// using two alternating line buffers; pixel values pass through unchanged.
module row_padding #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 5,
    parameter int TDEST_WIDTH = 2,
    parameter int MAX_COLS    = 1024
) (
    input  logic          clk,
    input  logic          rst,
    row_padding_if.slave  s_axis,
    row_padding_if.master m_axis
);
    localparam int LW = $clog2(MAX_COLS + 1);
    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_COLS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_NEXT = 2'd2
    } state_t;

    function automatic logic [2:0] repeat_count(input logic first_row, input logic last_row);
        logic [2:0] cnt;
        case ({first_row, last_row})
            2'b11:   cnt = 3'd5;
            2'b10:   cnt = 3'd3;
            2'b01:   cnt = 3'd3;
            2'b00:   cnt = 3'd1;
            default: cnt = 3'd1;
        endcase
        return cnt;
    endfunction

    // Line storage and per-buffer bookkeeping
    logic [TDATA_WIDTH-1:0] mem_r [2][MAX_COLS];
    logic [1:0]             full_r;
    logic [LW-1:0]          len_r [2];
    logic [2:0]             rep_r [2];
    logic                   buf_sof_r [2];
    logic                   buf_eof_r [2];
    logic [TUSER_WIDTH-1:0] buf_tuser_r [2];
    logic [TDEST_WIDTH-1:0] buf_tdest_r [2];

    // Write side
    logic                   wr_sel_r;
    logic [LW-1:0]          col_r;
    logic                   ready_r;
    logic                   expect_first_r;
    logic                   row_sof_r;
    logic [TUSER_WIDTH-1:0] frame_tuser_r;
    logic [TDEST_WIDTH-1:0] frame_tdest_r;
    logic                   accept_s;
    logic                   sof_s;
    logic                   eof_s;
    logic                   is_first_s;
    logic                   row_end_s;
    logic                   wr_sel_nxt_s;
    logic [1:0]             full_set_s;
    logic [1:0]             full_clr_s;
    logic [1:0]             full_nxt_s;

    // Read side
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   rd_sel_r;
    logic [LW-1:0]          rd_col_r;
    logic [2:0]             rd_rep_r;
    logic                   rd_first_r;
    logic                   advance_s;
    logic                   issue_s;
    logic                   repeat_s;
    logic                   toggle_s;
    logic                   load_s;
    logic                   load_sel_s;
    logic                   rd_last_col_s;
    logic [TUSER_WIDTH-1:0] beat_tuser_s;

    // Output register, doubling as the buffer read register
    logic                   out_valid_r;
    logic                   out_last_r;
    logic [TDATA_WIDTH-1:0] out_data_r;
    logic [TUSER_WIDTH-1:0] out_tuser_r;
    logic [TDEST_WIDTH-1:0] out_tdest_r;

    // Gating with rst keeps tready low while in reset yet high on the first free cycle
    assign s_axis.tready = ready_r & ~rst;
    assign m_axis.tvalid = out_valid_r;
    assign m_axis.tlast  = out_last_r;
    assign m_axis.tdata  = out_data_r;
    assign m_axis.tuser  = out_tuser_r;
    assign m_axis.tdest  = out_tdest_r;

    // Input beat decode, row classification and full-flag bookkeeping
    always_comb begin
        accept_s   = s_axis.tvalid & ready_r & ~rst;
        sof_s      = accept_s & s_axis.tuser[0];
        eof_s      = s_axis.tuser[1];
        row_end_s  = accept_s & s_axis.tlast;
        is_first_s = expect_first_r | row_sof_r | sof_s;
        full_set_s = 2'b00;
        if (row_end_s) begin
            full_set_s[wr_sel_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        full_nxt_s   = (full_r | full_set_s) & ~full_clr_s;
        wr_sel_nxt_s = row_end_s ? ~wr_sel_r : wr_sel_r;
    end

    // Write-side state: column counter, buffer descriptors, frame sideband capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_r       <= 1'b0;
            col_r          <= '0;
            ready_r        <= 1'b1;
            expect_first_r <= 1'b1;
            row_sof_r      <= 1'b0;
            frame_tuser_r  <= '0;
            frame_tdest_r  <= '0;
            full_r         <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                len_r[i]       <= '0;
                rep_r[i]       <= 3'd0;
                buf_sof_r[i]   <= 1'b0;
                buf_eof_r[i]   <= 1'b0;
                buf_tuser_r[i] <= '0;
                buf_tdest_r[i] <= '0;
            end
        end else begin
            full_r   <= full_nxt_s;
            wr_sel_r <= wr_sel_nxt_s;
            ready_r  <= ~full_nxt_s[wr_sel_nxt_s];
            if (sof_s) begin
                frame_tuser_r <= s_axis.tuser;
                frame_tdest_r <= s_axis.tdest;
            end
            if (row_end_s) begin
                col_r                 <= '0;
                len_r[wr_sel_r]       <= (col_r < MAX_LEN) ? col_r + LW'(1) : MAX_LEN;
                rep_r[wr_sel_r]       <= repeat_count(is_first_s, eof_s);
                buf_sof_r[wr_sel_r]   <= is_first_s;
                buf_eof_r[wr_sel_r]   <= eof_s;
                buf_tuser_r[wr_sel_r] <= sof_s ? s_axis.tuser : frame_tuser_r;
                buf_tdest_r[wr_sel_r] <= sof_s ? s_axis.tdest : frame_tdest_r;
                expect_first_r        <= eof_s;
                row_sof_r             <= 1'b0;
            end else if (accept_s) begin
                if (col_r < MAX_LEN) begin
                    col_r <= col_r + LW'(1);
                end
                row_sof_r <= row_sof_r | sof_s;
            end
        end
    end

    // Pixel storage; columns past MAX_COLS are discarded
    always_ff @(posedge clk) begin
        if (accept_s && (col_r < MAX_LEN)) begin
            mem_r[wr_sel_r][col_r[AW-1:0]] <= s_axis.tdata;
        end
    end

    // Read FSM next state and per-beat sideband
    always_comb begin
        state_nxt_s   = state_r;
        issue_s       = 1'b0;
        repeat_s      = 1'b0;
        toggle_s      = 1'b0;
        load_s        = 1'b0;
        full_clr_s    = 2'b00;
        advance_s     = ~out_valid_r | m_axis.tready;
        rd_last_col_s = (rd_col_r == (len_r[rd_sel_r] - LW'(1)));
        case (state_r)
            S_IDLE: begin
                if (full_r[rd_sel_r]) begin
                    state_nxt_s = S_EMIT;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_EMIT: begin
                if (advance_s) begin
                    issue_s = 1'b1;
                    if (rd_last_col_s) begin
                        state_nxt_s = S_NEXT;
                    end else begin
                        state_nxt_s = S_EMIT;
                    end
                end else begin
                    state_nxt_s = S_EMIT;
                end
            end
            S_NEXT: begin
                if (rd_rep_r > 3'd1) begin
                    repeat_s    = 1'b1;
                    state_nxt_s = S_EMIT;
                end else if (advance_s) begin
                    // Final repetition's last beat is leaving the output register now
                    full_clr_s[rd_sel_r] = 1'b1;
                    toggle_s             = 1'b1;
                    if (full_r[~rd_sel_r]) begin
                        state_nxt_s = S_EMIT;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    state_nxt_s = S_NEXT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
        load_sel_s      = toggle_s ? ~rd_sel_r : rd_sel_r;
        beat_tuser_s    = buf_tuser_r[rd_sel_r];
        beat_tuser_s[0] = buf_sof_r[rd_sel_r] & rd_first_r & (rd_col_r == '0);
        beat_tuser_s[1] = buf_eof_r[rd_sel_r] & (rd_rep_r == 3'd1) & rd_last_col_s;
    end

    // Read FSM registers and the output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rd_sel_r    <= 1'b0;
            rd_col_r    <= '0;
            rd_rep_r    <= 3'd0;
            rd_first_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_tuser_r <= '0;
            out_tdest_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= rd_last_col_s;
                out_data_r  <= mem_r[rd_sel_r][rd_col_r[AW-1:0]];
                out_tuser_r <= beat_tuser_s;
                out_tdest_r <= buf_tdest_r[rd_sel_r];
                rd_col_r    <= rd_last_col_s ? '0 : rd_col_r + LW'(1);
            end else if (advance_s) begin
                out_valid_r <= 1'b0;
            end
            if (repeat_s) begin
                rd_rep_r   <= rd_rep_r - 3'd1;
                rd_first_r <= 1'b0;
            end
            if (toggle_s) begin
                rd_sel_r <= ~rd_sel_r;
            end
            if (load_s) begin
                rd_rep_r   <= rep_r[load_sel_s];
                rd_first_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_row_padding.sv
// Directed bench for row_padding: frames are driven row by row and the output beat
// stream is compared against hand-built expected sequences.
module tb_row_padding;
    localparam int TW = 8;
    localparam int UW = 5;
    localparam int DW = 2;
    localparam int MC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    row_padding_if #(.TDATA_WIDTH(TW), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW)) s_if ();
    row_padding_if #(.TDATA_WIDTH(TW), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW)) m_if ();

    row_padding #(
        .TDATA_WIDTH(TW), .TUSER_WIDTH(UW), .TDEST_WIDTH(DW), .MAX_COLS(MC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] got_q [$];
    int          got_cyc [$];
    logic [15:0] exp_q [$];
    bit          rand_mode    = 1'b0;
    logic        tready_level = 1'b1;
    bit          seen_ready_low = 1'b0;
    bit          was_stalled    = 1'b0;
    logic [15:0] hold_beat      = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_level;
    end

    // Output monitor: collects handshaken beats and checks hold during stalls
    always @(negedge clk) begin
        logic [15:0] beat;
        beat = {m_if.tdest, m_if.tuser, m_if.tlast, m_if.tdata};
        if (rst) begin
            was_stalled = 1'b0;
        end else begin
            if (!s_if.tready) seen_ready_low = 1'b1;
            if (was_stalled) begin
                check("stall_valid", 32'(m_if.tvalid), 32'd1);
                check("stall_beat", 32'(beat), 32'(hold_beat));
            end
            if (m_if.tvalid && m_if.tready) begin
                got_q.push_back(beat);
                got_cyc.push_back(cyc);
            end
            was_stalled = m_if.tvalid && !m_if.tready;
            hold_beat   = beat;
        end
    end

    task automatic drive_beat(input logic [7:0] d, input logic [4:0] u,
                              input logic [1:0] dest, input logic last);
        bit done = 1'b0;
        int k = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tdest  = dest;
        s_if.tlast  = last;
        while (!done && k < 500) begin
            @(negedge clk);
            done = s_if.tready;
            @(posedge clk);
            #1;
            k++;
        end
        check("in_handshake", 32'(done), 32'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    // Sideband and tag appear only on the SOF beat so the DUT must hold its capture
    task automatic send_row(input int first, input int n, input bit sof, input bit eof,
                            input logic [1:0] dest, input logic [2:0] hi, input int cut);
        for (int i = 0; i < cut; i++) begin
            logic       s0;
            logic       s1;
            s0 = sof && (i == 0);
            s1 = eof && (i == n - 1);
            drive_beat(8'(first + i), {(s0 ? hi : 3'b000), s1, s0},
                       (s0 ? dest : 2'b00), (i == n - 1));
        end
    endtask

    task automatic add_rows(input int first, input int n, input int reps, input bit sof,
                            input bit eof, input logic [1:0] dest, input logic [2:0] hi);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < n; i++) begin
                logic u0;
                logic u1;
                u0 = sof && (r == 0) && (i == 0);
                u1 = eof && (r == reps - 1) && (i == n - 1);
                exp_q.push_back({dest, hi, u1, u0, (i == n - 1), 8'(first + i)});
            end
        end
    endtask

    task automatic finish_test(input string tag, input bit gapchk);
        int k = 0;
        while (got_q.size() < exp_q.size() && k < 3000) begin
            @(posedge clk);
            k++;
        end
        repeat (10) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_beat%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
                if (gapchk && i > 0) begin
                    if (exp_q[i-1][8])
                        check($sformatf("%s_rowgap%0d", tag, i),
                              32'(got_cyc[i] - got_cyc[i-1] <= 3), 32'd1);
                    else
                        check($sformatf("%s_pixgap%0d", tag, i),
                              32'(got_cyc[i] - got_cyc[i-1]), 32'd1);
                end
            end
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tdest  = '0;
        s_if.tlast  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_data",  32'(m_if.tdata),  32'd0);
        check("rst_m_user",  32'(m_if.tuser),  32'd0);
        check("rst_s_ready", 32'(s_if.tready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(s_if.tready), 32'd1);
        @(posedge clk);
        #1;

        // 4x3 frame, always ready
        tready_level = 1'b1;
        add_rows(1, 4, 3, 1'b1, 1'b0, 2'b01, 3'b110);
        add_rows(5, 4, 1, 1'b0, 1'b0, 2'b01, 3'b110);
        add_rows(9, 4, 3, 1'b0, 1'b1, 2'b01, 3'b110);
        send_row(1, 4, 1'b1, 1'b0, 2'b01, 3'b110, 4);
        send_row(5, 4, 1'b0, 1'b0, 2'b01, 3'b110, 4);
        send_row(9, 4, 1'b0, 1'b1, 2'b01, 3'b110, 4);
        finish_test("frame4x3", 1'b1);

        // single-row frame
        add_rows(7, 3, 5, 1'b1, 1'b1, 2'b10, 3'b001);
        send_row(7, 3, 1'b1, 1'b1, 2'b10, 3'b001, 3);
        finish_test("single_row", 1'b1);

        // 4x3 frame with random output back-pressure
        seen_ready_low = 1'b0;
        rand_mode = 1'b1;
        add_rows(1, 4, 3, 1'b1, 1'b0, 2'b11, 3'b011);
        add_rows(5, 4, 1, 1'b0, 1'b0, 2'b11, 3'b011);
        add_rows(9, 4, 3, 1'b0, 1'b1, 2'b11, 3'b011);
        send_row(1, 4, 1'b1, 1'b0, 2'b11, 3'b011, 4);
        send_row(5, 4, 1'b0, 1'b0, 2'b11, 3'b011, 4);
        send_row(9, 4, 1'b0, 1'b1, 2'b11, 3'b011, 4);
        finish_test("random_ready", 1'b0);
        rand_mode = 1'b0;
        check("ready_dropped", 32'(seen_ready_low), 32'd1);

        // overlong row: MAX_COLS+3 pixels, only the first MAX_COLS kept
        add_rows(1, MC, 5, 1'b1, 1'b1, 2'b00, 3'b100);
        send_row(1, MC + 3, 1'b1, 1'b1, 2'b00, 3'b100, MC + 3);
        finish_test("overlong", 1'b1);

        // reset after 1.5 rows, then a fresh 2x2 frame
        send_row(1, 4, 1'b1, 1'b0, 2'b01, 3'b101, 4);
        send_row(5, 4, 1'b0, 1'b0, 2'b01, 3'b101, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_m_valid", 32'(m_if.tvalid), 32'd0);
        check("midrst_m_last",  32'(m_if.tlast),  32'd0);
        check("midrst_m_data",  32'(m_if.tdata),  32'd0);
        check("midrst_m_user",  32'(m_if.tuser),  32'd0);
        check("midrst_m_dest",  32'(m_if.tdest),  32'd0);
        check("midrst_s_ready", 32'(s_if.tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        got_cyc.delete();
        #1;
        check("midrst_ready_after", 32'(s_if.tready), 32'd1);
        add_rows(20, 2, 3, 1'b1, 1'b0, 2'b10, 3'b111);
        add_rows(22, 2, 3, 1'b0, 1'b1, 2'b10, 3'b111);
        send_row(20, 2, 1'b1, 1'b0, 2'b10, 3'b111, 2);
        send_row(22, 2, 1'b0, 1'b1, 2'b10, 3'b111, 2);
        finish_test("after_rst", 1'b1);

        // two back-to-back 2x2 frames with different tags
        add_rows(30, 2, 3, 1'b1, 1'b0, 2'b01, 3'b101);
        add_rows(32, 2, 3, 1'b0, 1'b1, 2'b01, 3'b101);
        add_rows(40, 2, 3, 1'b1, 1'b0, 2'b10, 3'b010);
        add_rows(42, 2, 3, 1'b0, 1'b1, 2'b10, 3'b010);
        send_row(30, 2, 1'b1, 1'b0, 2'b01, 3'b101, 2);
        send_row(32, 2, 1'b0, 1'b1, 2'b01, 3'b101, 2);
        send_row(40, 2, 1'b1, 1'b0, 2'b10, 3'b010, 2);
        send_row(42, 2, 1'b0, 1'b1, 2'b10, 3'b010, 2);
        finish_test("b2b_frames", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/row_padding.md
ROW_PADDING -- requirements
Module: row_padding

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 8, pixel width.
REQ-002 SHALL have parameter TUSER_WIDTH, default 5, sideband width (min 2).
REQ-003 SHALL have parameter TDEST_WIDTH, default 2, routing tag width.
REQ-004 SHALL have parameter MAX_COLS, default 1024, maximum pixels per row.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have slave ports: s_axis_tdata in TDATA_WIDTH; s_axis_tuser in TUSER_WIDTH; s_axis_tdest in TDEST_WIDTH; s_axis_tvalid in 1; s_axis_tready out 1; s_axis_tlast in 1 end of row.
REQ-007 SHALL have master ports: m_axis_tdata out TDATA_WIDTH; m_axis_tuser out TUSER_WIDTH; m_axis_tdest out TDEST_WIDTH; m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tlast out 1 end of row.
REQ-008 Input convention: tuser[0]=start of frame on first pixel; tlast ends each row; tuser[1]=end of frame, valid only with tlast of last row.

Function
REQ-009 Block SHALL sit downstream of the column padding stage and add 2 replicated rows at frame top and 2 at frame bottom; pixel data SHALL be unmodified.
REQ-010 Output frame SHALL be: first row x3, each middle row x1, last row x3; single-row frame: that row x5; R input rows yield R+4 output rows.
REQ-011 Two line buffers (A/B), each MAX_COLS x TDATA_WIDTH, plus per-buffer length, repeat count and full flag; input fills them alternately starting with A after reset.
REQ-012 Beat accepted when s_axis_tvalid & s_axis_tready; accepted pixel written at column counter address; counter increments, clears on tlast.
REQ-013 Pixels beyond MAX_COLS in a row SHALL be dropped; stored length saturates at MAX_COLS; tlast still closes the row.
REQ-014 On tlast accept: buffer marked full, length latched, repeat = 5 if first-row-and-EOF, 3 if first row or EOF, else 1.
REQ-015 s_axis_tready SHALL be registered, high iff current write buffer not full; no combinational path from m_axis_tready.
REQ-016 Read FSM states: S_IDLE (no full buffer), S_EMIT (stream row from read buffer), S_NEXT (decrement repeat; if nonzero re-emit same buffer else free it, toggle read buffer, go S_IDLE or S_EMIT).
REQ-017 Buffer read latency 1 cycle; output register SHALL hold tdata/tuser/tdest/tlast stable while m_axis_tvalid & !m_axis_tready.
REQ-018 Sustained throughput SHALL be 1 pixel/cycle within a row when m_axis_tready=1; at most 2 idle cycles between output rows.
REQ-019 m_axis_tlast SHALL assert on last pixel of every output row.
REQ-020 m_axis_tuser[0] SHALL assert only on first pixel of first output row; tuser[1] only on last pixel of final output row; bits [TUSER_WIDTH-1:2] and tdest SHALL equal values captured at input SOF beat, held for the frame.
REQ-021 Write and read of same buffer never overlap: a full buffer is not written; a buffer is freed only after its final repetition's last beat handshakes.
REQ-022 Back-to-back frames: next frame's first row MAY fill the free buffer while previous frame's bottom padding is emitted; frame ordering preserved.
REQ-023 tuser[0] arriving mid-frame SHALL restart row classification (treated as first row); previously full buffers drain unchanged.

Reset
REQ-024 During rst: m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdest, m_axis_tdata = 0; s_axis_tready = 0; full flags, counters cleared; FSM to S_IDLE; write/read pointers to A.
REQ-025 First cycle after rst deassert s_axis_tready SHALL be 1; buffer RAM contents need not be cleared.
REQ-026 Reset mid-frame SHALL discard all stored rows and any in-flight output beat.

Verification
REQ-027 4-col x 3-row frame rows {1,2,3,4},{5,6,7,8},{9,10,11,12}, tready=1 -> 7 rows: r0,r0,r0,r1,r2,r2,r2; tlast each row; tuser[0] on first "1"; tuser[1] on final "12".
REQ-028 Single row {7,8,9} -> 5 identical rows, tuser[0] first beat, tuser[1] last beat, 15 beats total.
REQ-029 Random m_axis_tready (50%) on REQ-027 frame -> identical output sequence, data stable during stalls, s_axis_tready drops when both buffers full.
REQ-030 Row of MAX_COLS+3 pixels -> output rows of exactly MAX_COLS pixels, tlast on pixel MAX_COLS.
REQ-031 rst asserted after 1.5 rows of a frame -> outputs zero next cycle; fresh 2x2 frame afterwards yields 6 correct rows.
REQ-032 Two back-to-back 2x2 frames, tdest 1 then 2 -> 12 rows in order, tdest correct per frame, no bubbles beyond REQ-018.
